// File: rtl/heat_sched.sv
// heat_sched: Gauss-Seidel heat-diffusion solver engine driving a single-port cell RAM,
// with a host access port that shares the RAM while the engine is idle.
`default_nettype none

module heat_sched #(
    parameter  int GRID  = 5,
    parameter  int DW    = 4,
    localparam int CELLS = GRID * GRID,
    localparam int AW    = $clog2(CELLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    input  logic          start,
    input  logic [3:0]    n_iter,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [3:0]    iter_cnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(GRID);
    localparam logic [AW-1:0] C_GRID     = AW'(GRID);
    localparam logic [AW-1:0] C_FIRST    = AW'(GRID + 1);
    localparam logic [AW-1:0] C_LAST     = AW'(CELLS - GRID - 2);
    localparam logic [AW:0]   C_CELLS    = (AW+1)'(CELLS);
    localparam logic [CW-1:0] C_COL_LAST = CW'(GRID - 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RD3  = 3'd4,
        S_ACC  = 3'd5,
        S_WB   = 3'd6
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cell;
    logic [CW-1:0]   r_col;
    logic [3:0]      r_n_iter;
    logic [3:0]      r_iter_cnt;
    logic            r_abort;
    logic [DW+1:0]   r_sum;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_pend;
    logic            r_rd_oor;
    logic            r_rvalid;
    logic [DW-1:0]   r_rdata;

    logic            w_host_acc;
    logic            w_addr_ok;
    logic            w_last_cell;
    logic            w_stop;
    logic            w_final_iter;

    assign host_ready   = (r_state == S_IDLE) && !start && !rst;
    assign w_host_acc   = host_valid && host_ready;
    assign w_addr_ok    = {1'b0, host_addr} < C_CELLS;
    assign w_last_cell  = (r_cell == C_LAST);
    assign w_stop       = r_abort || abort;
    assign w_final_iter = w_last_cell && ((r_iter_cnt + 4'd1) == r_n_iter);

    assign busy        = r_busy;
    assign done        = r_done;
    assign iter_cnt    = r_iter_cnt;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rdata;

    // RAM port mux: host owns it in IDLE, the engine walks the four neighbours otherwise.
    always_comb begin
        mem_addr  = host_addr;
        mem_we    = 1'b0;
        mem_wdata = host_wdata;
        case (r_state)
            S_IDLE: mem_we = w_host_acc && host_we && w_addr_ok;
            S_RD0:  mem_addr = r_cell - C_GRID;
            S_RD1:  mem_addr = r_cell + C_GRID;
            S_RD2:  mem_addr = r_cell - 1'b1;
            S_RD3:  mem_addr = r_cell + 1'b1;
            S_WB: begin
                mem_addr  = r_cell;
                mem_we    = !rst;
                mem_wdata = r_sum[DW+1:2];
            end
            default: mem_addr = r_cell;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cell     <= C_FIRST;
            r_col      <= CW'(1);
            r_n_iter   <= 4'd0;
            r_iter_cnt <= 4'd0;
            r_abort    <= 1'b0;
            r_sum      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_oor   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_done    <= 1'b0;
            r_rd_pend <= w_host_acc && !host_we;
            r_rd_oor  <= !w_addr_ok;
            r_rvalid  <= r_rd_pend;
            if (r_rd_pend)
                r_rdata <= r_rd_oor ? '0 : mem_rdata;
            if (r_busy && abort)
                r_abort <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_iter_cnt <= 4'd0;
                        if (n_iter == 4'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= S_RD0;
                            r_busy   <= 1'b1;
                            r_n_iter <= n_iter;
                            r_cell   <= C_FIRST;
                            r_col    <= CW'(1);
                            r_sum    <= '0;
                            r_abort  <= 1'b0;
                        end
                    end
                end
                S_RD0: r_state <= S_RD1;
                S_RD1: begin
                    r_sum   <= r_sum + {2'b00, mem_rdata};
                    r_state <= S_RD2;
                end
                S_RD2: begin
                    r_sum   <= r_sum + {2'b00, mem_rdata};
                    r_state <= S_RD3;
                end
                S_RD3: begin
                    r_sum   <= r_sum + {2'b00, mem_rdata};
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_sum   <= r_sum + {2'b00, mem_rdata};
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_sum <= '0;
                    if (w_last_cell) begin
                        r_iter_cnt <= r_iter_cnt + 4'd1;
                        r_cell     <= C_FIRST;
                        r_col      <= CW'(1);
                    end else if (r_col == C_COL_LAST) begin
                        // skip the right edge of this row and the left edge of the next
                        r_cell <= r_cell + AW'(3);
                        r_col  <= CW'(1);
                    end else begin
                        r_cell <= r_cell + 1'b1;
                        r_col  <= r_col + 1'b1;
                    end
                    if (w_stop || w_final_iter) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_abort <= 1'b0;
                    end else begin
                        r_state <= S_RD0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_heat_sched.sv
// tb_heat_sched: directed, table-driven bench for heat_sched with a behavioural single-port RAM.
`default_nettype none

module tb_heat_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_valid = 1'b0;
    logic       host_we = 1'b0;
    logic [4:0] host_addr = 5'd0;
    logic [3:0] host_wdata = 4'd0;
    logic       host_ready;
    logic [3:0] host_rdata;
    logic       host_rvalid;
    logic       start = 1'b0;
    logic [3:0] n_iter = 4'd0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] iter_cnt;
    logic [4:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;

    logic [3:0] ram [0:31];
    int         n_we = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    heat_sched #(.GRID(5), .DW(4)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .start(start), .n_iter(n_iter), .abort(abort),
        .busy(busy), .done(done), .iter_cnt(iter_cnt), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
            n_we <= n_we + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [3:0] wdata;
        logic       exp_we;
        logic [3:0] exp_rdata;
    } host_vec_t;

    host_vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mode 0: all zero except cell 2 = 12; mode 1: edges 15, interior 0
    task automatic load_grid(input int mode);
        for (int a = 0; a < 32; a++) ram[a] = 4'd0;
        if (mode == 0) begin
            ram[2] = 4'd12;
        end else begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    if (r == 0 || r == 4 || c == 0 || c == 4) ram[r*5+c] = 4'd15;
        end
    endtask

    // Drives start in cycle T (cycle 0) and runs until done or a cycle budget expires.
    task automatic run(input logic [3:0] n, input int abort_at,
                       output int done_at, output int busy_cnt, output logic ready_at_start);
        done_at  = -1;
        busy_cnt = 0;
        start    = 1'b1;
        n_iter   = n;
        #2;
        ready_at_start = host_ready;
        tick();
        start      = 1'b0;
        host_valid = 1'b0;
        for (int c = 1; c < 2000; c++) begin
            abort = (c == abort_at);
            #2;
            if (busy) busy_cnt++;
            if (done) begin
                done_at = c;
                break;
            end
            tick();
        end
        abort = 1'b0;
        chk("done_seen", 32'(done_at >= 0), 32'd1);
    endtask

    int   d_at, b_cnt, we0, bad_edges, nz;
    logic rdy;

    initial begin
        for (int a = 0; a < 32; a++) ram[a] = 4'd0;

        // reset state
        tick(); tick();
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_iter", 32'(iter_cnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_ready", 32'(host_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // host access table
        vecs[0] = '{1'b1, 5'd12, 4'd10, 1'b1, 4'd0};
        vecs[1] = '{1'b0, 5'd12, 4'd0,  1'b0, 4'd10};
        vecs[2] = '{1'b1, 5'd30, 4'd5,  1'b0, 4'd0};
        vecs[3] = '{1'b0, 5'd30, 4'd0,  1'b0, 4'd0};
        vecs[4] = '{1'b1, 5'd24, 4'd7,  1'b1, 4'd0};
        vecs[5] = '{1'b0, 5'd24, 4'd0,  1'b0, 4'd7};
        vecs[6] = '{1'b1, 5'd0,  4'd3,  1'b1, 4'd0};
        vecs[7] = '{1'b0, 5'd0,  4'd0,  1'b0, 4'd3};
        for (int i = 0; i < 8; i++) begin
            host_valid = 1'b1;
            host_we    = vecs[i].we;
            host_addr  = vecs[i].addr;
            host_wdata = vecs[i].wdata;
            #2;
            chk($sformatf("v%0d_ready", i), 32'(host_ready), 32'd1);
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            tick();
            host_valid = 1'b0;
            #2;
            chk($sformatf("v%0d_rvalid_t1", i), 32'(host_rvalid), 32'd0);
            tick();
            #2;
            chk($sformatf("v%0d_rvalid_t2", i), 32'(host_rvalid), 32'(!vecs[i].we));
            if (!vecs[i].we)
                chk($sformatf("v%0d_rdata", i), 32'(host_rdata), 32'(vecs[i].exp_rdata));
            tick();
            #2;
            chk($sformatf("v%0d_rvalid_t3", i), 32'(host_rvalid), 32'd0);
            tick();
        end

        // back-to-back reads
        host_valid = 1'b1; host_we = 1'b0; host_addr = 5'd12;
        tick();
        host_addr = 5'd24;
        tick();
        host_valid = 1'b0;
        #2;
        chk("b2b_rvalid0", 32'(host_rvalid), 32'd1);
        chk("b2b_rdata0", 32'(host_rdata), 32'd10);
        tick();
        #2;
        chk("b2b_rvalid1", 32'(host_rvalid), 32'd1);
        chk("b2b_rdata1", 32'(host_rdata), 32'd7);
        tick();
        #2;
        chk("b2b_rvalid_end", 32'(host_rvalid), 32'd0);
        tick();

        // in-flight read dropped by reset
        host_valid = 1'b1; host_we = 1'b0; host_addr = 5'd12;
        tick();
        host_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("drop_rvalid_t2", 32'(host_rvalid), 32'd0);
        tick();
        #2;
        chk("drop_rvalid_t3", 32'(host_rvalid), 32'd0);
        tick();

        // single hot boundary cell, one iteration
        load_grid(0);
        run(4'd1, -1, d_at, b_cnt, rdy);
        chk("hot_done_at", 32'(d_at), 32'd55);
        chk("hot_busy_cycles", 32'(b_cnt), 32'd54);
        chk("hot_busy_at_done", 32'(busy), 32'd0);
        chk("hot_ready_at_done", 32'(host_ready), 32'd1);
        chk("hot_iter", 32'(iter_cnt), 32'd1);
        tick();
        #2;
        chk("hot_done_1cyc", 32'(done), 32'd0);
        chk("hot_cell7", 32'(ram[7]), 32'd3);
        chk("hot_cell2", 32'(ram[2]), 32'd12);
        nz = 0;
        for (int a = 0; a < 25; a++) if (a != 2 && a != 7 && ram[a] != 4'd0) nz++;
        chk("hot_others_zero", 32'(nz), 32'd0);
        tick();

        // hot edges, one iteration
        load_grid(1);
        run(4'd1, -1, d_at, b_cnt, rdy);
        chk("edge_done_at", 32'(d_at), 32'd55);
        tick();
        chk("edge_cell6", 32'(ram[6]), 32'd7);
        chk("edge_cell7", 32'(ram[7]), 32'd5);
        chk("edge_cell8", 32'(ram[8]), 32'd8);
        chk("edge_cell12", 32'(ram[12]), 32'd2);
        chk("edge_cell18", 32'(ram[18]), 32'd10);
        bad_edges = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if ((r == 0 || r == 4 || c == 0 || c == 4) && ram[r*5+c] != 4'd15) bad_edges++;
        chk("edge_unchanged", 32'(bad_edges), 32'd0);

        // abort in IDLE has no effect; abort at cycle 60 of a 3-iteration run
        abort = 1'b1;
        tick();
        abort = 1'b0;
        load_grid(1);
        run(4'd3, 60, d_at, b_cnt, rdy);
        chk("abort_done_at", 32'(d_at), 32'd61);
        chk("abort_busy_cycles", 32'(b_cnt), 32'd60);
        chk("abort_iter", 32'(iter_cnt), 32'd1);
        tick();
        chk("abort_cell6", 32'(ram[6]), 32'd10);
        chk("abort_cell7", 32'(ram[7]), 32'd5);

        // two iterations back to back
        load_grid(1);
        run(4'd2, -1, d_at, b_cnt, rdy);
        chk("two_done_at", 32'(d_at), 32'd109);
        chk("two_busy_cycles", 32'(b_cnt), 32'd108);
        chk("two_iter", 32'(iter_cnt), 32'd2);
        tick();
        chk("two_cell6", 32'(ram[6]), 32'd10);

        // zero-iteration run
        we0 = n_we;
        run(4'd0, -1, d_at, b_cnt, rdy);
        chk("zero_done_at", 32'(d_at), 32'd1);
        chk("zero_busy", 32'(b_cnt), 32'd0);
        chk("zero_iter", 32'(iter_cnt), 32'd0);
        tick();
        chk("zero_no_write", 32'(n_we - we0), 32'd0);

        // start and host write in the same cycle: start wins
        load_grid(1);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 5'd0; host_wdata = 4'd9;
        run(4'd1, -1, d_at, b_cnt, rdy);
        chk("prio_ready", 32'(rdy), 32'd0);
        chk("prio_busy_cycles", 32'(b_cnt), 32'd54);
        tick();
        chk("prio_cell0", 32'(ram[0]), 32'd15);

        // reset in cycle 20 of a run
        load_grid(1);
        start = 1'b1; n_iter = 4'd1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        we0 = n_we;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rstrun_busy", 32'(busy), 32'd0);
        repeat (60) tick();
        chk("rstrun_no_write", 32'(n_we - we0), 32'd0);
        chk("rstrun_cell6", 32'(ram[6]), 32'd7);
        chk("rstrun_cell7", 32'(ram[7]), 32'd5);
        chk("rstrun_cell8", 32'(ram[8]), 32'd8);
        chk("rstrun_cell11", 32'(ram[11]), 32'd0);
        chk("rstrun_cell0", 32'(ram[0]), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
